// File: rtl/param_seq_mult_if.sv
// -----------------------------------------------------------------------------
// param_seq_mult_if
// Operand/result bundle for the sequential shift-add multiplier.
//
// Handshake: the requester drives GO, SIGNED_MODE, A and B. They are sampled
// on a rising clock edge only while READY is high. The multiplier then drops
// READY, ignores all four inputs until it is idle again, and raises DONE for
// exactly one cycle together with the new Y_REG value. Y_REG holds its value
// until the next completion.
//
// Signals
//   GO           requester -> multiplier   start request (level sampled)
//   SIGNED_MODE  requester -> multiplier   1 = two's-complement operands
//   A            requester -> multiplier   multiplicand
//   B            requester -> multiplier   multiplier
//   Y_REG        multiplier -> requester   registered product
//   READY        multiplier -> requester   idle, a GO will be accepted
//   DONE         multiplier -> requester   one-cycle completion pulse
// -----------------------------------------------------------------------------
interface param_seq_mult_if #(
   parameter int MULTIPLICAND_WIDTH = 8,
   parameter int MULTIPLIER_WIDTH   = 8
);
   localparam int PRODUCT_WIDTH = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;

   logic                          GO;
   logic                          SIGNED_MODE;
   logic [MULTIPLICAND_WIDTH-1:0] A;
   logic [MULTIPLIER_WIDTH-1:0]   B;
   logic [PRODUCT_WIDTH-1:0]      Y_REG;
   logic                          READY;
   logic                          DONE;

   modport master (
      output GO, SIGNED_MODE, A, B,
      input  Y_REG, READY, DONE
   );

   modport slave (
      input  GO, SIGNED_MODE, A, B,
      output Y_REG, READY, DONE
   );
endinterface

// File: rtl/param_seq_mult.sv
// -----------------------------------------------------------------------------
// param_seq_mult
// Sequential shift-add multiplier with unsigned and two's-complement modes.
// Operands are captured as magnitudes plus a negate flag, multiplied by one
// shift-add iteration per cycle, and the (optionally negated) product is
// registered in the FINISH state.
//
// Ports
//   SYS_CLOCK    in   clock, rising edge
//   FSM_ARESET   in   asynchronous active-low reset
//   bus          slave modport of param_seq_mult_if (GO/SIGNED_MODE/A/B in,
//                Y_REG/READY/DONE out)
//   dbg_state_o  out  current FSM state (IDLE=0, CALC=1, FINISH=2)
//
// Optional feature
//   MULT_EARLY_TERM_EN  when defined, CALC ends after the first iteration
//                       that leaves the shifted multiplier at zero.
// -----------------------------------------------------------------------------
module param_seq_mult #(
   parameter int MULTIPLICAND_WIDTH = 8,
   parameter int MULTIPLIER_WIDTH   = 8
) (
   input  logic                   SYS_CLOCK,
   input  logic                   FSM_ARESET,
   param_seq_mult_if.slave        bus,
   output logic [1:0]             dbg_state_o
);
   localparam int PRODUCT_WIDTH = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
   localparam int CW            = $clog2(MULTIPLIER_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CALC   = 2'b01,
      FINISH = 2'b10
   } state_t;

   state_t                        state_q, state_d;
   logic [PRODUCT_WIDTH-1:0]      mcand_q, mcand_d;
   logic [MULTIPLIER_WIDTH-1:0]   mplier_q, mplier_d;
   logic [PRODUCT_WIDTH-1:0]      acc_q, acc_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          neg_q, neg_d;
   logic [PRODUCT_WIDTH-1:0]      y_q, y_d;
   logic                          done_q, done_d;

   // Magnitudes are held unsigned at full operand width, so the most negative
   // value (e.g. -128 -> 128) is represented exactly.
   logic                          a_neg, b_neg;
   logic [MULTIPLICAND_WIDTH-1:0] a_mag;
   logic [MULTIPLIER_WIDTH-1:0]   b_mag;
   logic                          last_iter;

   assign a_neg = bus.SIGNED_MODE & bus.A[MULTIPLICAND_WIDTH-1];
   assign b_neg = bus.SIGNED_MODE & bus.B[MULTIPLIER_WIDTH-1];
   assign a_mag = a_neg ? ((~bus.A) + MULTIPLICAND_WIDTH'(1)) : bus.A;
   assign b_mag = b_neg ? ((~bus.B) + MULTIPLIER_WIDTH'(1)) : bus.B;

   // The counter holds the iterations still to run, including the current one.
`ifdef MULT_EARLY_TERM_EN
   assign last_iter = (cnt_q == CW'(1)) || ((mplier_q >> 1) == '0);
`else
   assign last_iter = (cnt_q == CW'(1));
`endif

   always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET) begin
      if (!FSM_ARESET) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         y_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         y_q      <= y_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      y_d      = y_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.GO) begin
               mcand_d  = {{MULTIPLIER_WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               cnt_d    = CW'(MULTIPLIER_WIDTH);
               neg_d    = a_neg ^ b_neg;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q - CW'(1);
            if (last_iter) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            // Negating a zero accumulator yields zero, so no negative zero.
            y_d     = neg_q ? ((~acc_q) + PRODUCT_WIDTH'(1)) : acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.Y_REG   = y_q;
   assign bus.DONE    = done_q;
   assign bus.READY   = (state_q == IDLE);
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_param_seq_mult.sv
module tb_param_seq_mult;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int PW = AW + BW;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  param_seq_mult_if #(.MULTIPLICAND_WIDTH(AW), .MULTIPLIER_WIDTH(BW)) bus ();

  param_seq_mult #(.MULTIPLICAND_WIDTH(AW), .MULTIPLIER_WIDTH(BW)) dut (
    .SYS_CLOCK  (clk),
    .FSM_ARESET (rst_n),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural reference ----------------
  function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                              input logic s);
    longint av;
    longint bv;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    return PW'(av * bv);
  endfunction

  function automatic int ref_lat(input logic [BW-1:0] b, input logic s);
    longint bv;
    longint mag;
    int hi;
    bv  = s ? longint'($signed(b)) : longint'(b);
    mag = (bv < 0) ? -bv : bv;
    if (!EARLY) return BW + 1;
    if (mag == 0) return 2;
    hi = 0;
    for (int i = 0; i < 40; i++) if (((mag >> i) & 1) == 1) hi = i;
    return hi + 2;
  endfunction

  // Transaction-level model: idle/busy, the edge at which the result lands,
  // and the value that lands there.
  logic          m_idle;
  logic          m_done;
  logic [PW-1:0] m_y;
  logic [PW-1:0] m_pend;
  int            m_edge;
  int            m_end;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_y    <= '0;
      m_pend <= '0;
      m_edge <= 0;
      m_end  <= 0;
    end else begin
      m_edge <= m_edge + 1;
      m_done <= 1'b0;
      if (m_idle && bus.GO) begin
        m_idle <= 1'b0;
        m_pend <= ref_prod(bus.A, bus.B, bus.SIGNED_MODE);
        m_end  <= m_edge + ref_lat(bus.B, bus.SIGNED_MODE);
      end else if (!m_idle && (m_edge == m_end)) begin
        m_idle <= 1'b1;
        m_y    <= m_pend;
        m_done <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_cmp();
    if (rst_n) begin
      vectors++;
      if (bus.READY !== m_idle || bus.DONE !== m_done || bus.Y_REG !== m_y) begin
        miscompares++;
        $display("FAIL cycle: READY=%b DONE=%b Y=0x%0h expected READY=%b DONE=%b Y=0x%0h at %0t",
                 bus.READY, bus.DONE, bus.Y_REG, m_idle, m_done, m_y, $time);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Compare on the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    cycle_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input bit with_go);
    int sel;
    sel = $urandom_range(0, 7);
    bus.A = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h80 : (sel == 2) ? 8'hFF : 8'($urandom);
    sel = $urandom_range(0, 7);
    bus.B = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h80 : (sel == 2) ? 8'hFF : 8'($urandom);
    bus.SIGNED_MODE = 1'($urandom);
    if (with_go) bus.GO = 1'($urandom);
  endtask

  // Counts edges after the start edge until DONE, bounded.
  task automatic wait_done(input bit toggle, output int n, output int low_cnt);
    bit got;
    n = 0;
    got = 0;
    low_cnt = 0;
    while (n < 40 && !got) begin
      if (toggle) rand_ops(1'b0);
      tick();
      n++;
      if (bus.DONE) got = 1;
      else if (!bus.READY) low_cnt++;
    end
    if (!got) chk("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [PW-1:0] exp_y, input int exp_lat, input bit toggle,
                       output int low_cnt);
    int n;
    int lc;
    bus.A = a;
    bus.B = b;
    bus.SIGNED_MODE = s;
    bus.GO = 1'b1;
    tick();
    chk({nm, "_ready_drop"}, 32'(bus.READY), 32'(0));
    bus.GO = 1'b0;
    wait_done(toggle, n, lc);
    low_cnt = lc + 1;
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_y"}, 32'(bus.Y_REG), 32'(exp_y));
    chk({nm, "_model_y"}, 32'(m_y), 32'(exp_y));
    chk({nm, "_ready_back"}, 32'(bus.READY), 32'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lc;
    int n;
    int done_edges[$];
    bus.GO = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.SIGNED_MODE = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.READY), 32'(1));
    chk("reset_done", 32'(bus.DONE), 32'(0));
    chk("reset_y", 32'(bus.Y_REG), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed products with hand-computed results.
    do_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, EARLY ? 5 : 9, 1'b0, lc);
    if (!EARLY) chk("u13x11_ready_low_cycles", 32'(lc), 32'(9));
    do_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, 1'b0, lc);
    do_op("s_m128x_m128", 8'h80, 8'h80, 1'b1, 16'h4000, 9, 1'b0, lc);
    do_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, EARLY ? 4 : 9, 1'b0, lc);
    do_op("s_0x_m7_toggle", 8'h00, 8'hF9, 1'b1, 16'h0000, EARLY ? 4 : 9, 1'b1, lc);
    do_op("s_m3x5_toggle", 8'hFD, 8'h05, 1'b1, 16'hFFF1, EARLY ? 4 : 9, 1'b1, lc);

    // GO held high: back-to-back operations one idle cycle apart.
    bus.A = 8'd200;
    bus.B = 8'h93;
    bus.SIGNED_MODE = 1'b0;
    bus.GO = 1'b1;
    tick();
    n = 0;
    while (n < 60 && done_edges.size() < 3) begin
      tick();
      n++;
      if (bus.DONE) begin
        done_edges.push_back(n);
        chk("held_y", 32'(bus.Y_REG), 32'(16'd29400));
      end
    end
    bus.GO = 1'b0;
    chk("held_count", 32'(done_edges.size()), 32'(3));
    if (done_edges.size() == 3) begin
      chk("held_space1", 32'(done_edges[1] - done_edges[0]), 32'(10));
      chk("held_space2", 32'(done_edges[2] - done_edges[1]), 32'(10));
    end

    // Reset during CALC aborts; first GO after release is taken at once.
    bus.A = 8'h55;
    bus.B = 8'hAA;
    bus.GO = 1'b1;
    tick();
    bus.GO = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.READY), 32'(1));
    chk("abort_done", 32'(bus.DONE), 32'(0));
    chk("abort_y", 32'(bus.Y_REG), 32'(0));
    bus.A = 8'd6;
    bus.B = 8'd7;
    bus.SIGNED_MODE = 1'b0;
    bus.GO = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_accept", 32'(bus.READY), 32'(0));
    bus.GO = 1'b0;
    wait_done(1'b0, n, lc);
    chk("post_reset_lat", 32'(n), 32'(EARLY ? 4 : 9));
    chk("post_reset_y", 32'(bus.Y_REG), 32'(42));

    // Multiplier patterns that exercise early termination when enabled.
    do_op("u_b1", 8'd77, 8'h01, 1'b0, 16'd77, EARLY ? 2 : 9, 1'b0, lc);
    do_op("u_b80", 8'd3, 8'h80, 1'b0, 16'd384, 9, 1'b0, lc);
    do_op("u_b0", 8'hFF, 8'h00, 1'b0, 16'h0000, EARLY ? 2 : 9, 1'b0, lc);
    do_op("s_b0_neg", 8'h81, 8'h00, 1'b1, 16'h0000, EARLY ? 2 : 9, 1'b0, lc);

    // Random traffic: every input changes every cycle, GO included.
    for (int i = 0; i < 600; i++) begin
      rand_ops(1'b1);
      tick();
    end
    bus.GO = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/param_seq_mult.md
PARAM_SEQ_MULT -- requirements
Module: param_seq_mult

Interface
REQ-001 Parameter MULTIPLICAND_WIDTH, default 8: width of A, legal range 2..32.
REQ-002 Parameter MULTIPLIER_WIDTH, default 8: width of B, legal range 2..32; also sets the CALC iteration count.
REQ-003 Parameter PRODUCT_WIDTH, default MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH: derived only, never overridden.
REQ-004 SYS_CLOCK  in  1: single clock; all state updates on the rising edge.
REQ-005 FSM_ARESET  in  1: reset, asynchronous, active-low.
REQ-006 GO  in  1: start request, level-sampled.
REQ-007 SIGNED_MODE  in  1: 1 = two's-complement operands, 0 = unsigned; sampled together with A and B.
REQ-008 A  in  MULTIPLICAND_WIDTH: multiplicand.
REQ-009 B  in  MULTIPLIER_WIDTH: multiplier.
REQ-010 Y_REG  out  PRODUCT_WIDTH: registered product, held until the next completion.
REQ-011 READY  out  1: high in IDLE only; block accepts GO.
REQ-012 DONE  out  1: one-cycle pulse coinciding with a new Y_REG value.

Function
REQ-013 FSM states SHALL be IDLE, CALC and FINISH; any unused encoding SHALL return to IDLE.
REQ-014 IDLE with GO=1 at edge k: register A, B and SIGNED_MODE, clear the accumulator, load the counter with MULTIPLIER_WIDTH, go to CALC.
REQ-015 In signed mode, capture SHALL store |A| and |B| plus a negate flag equal to sign(A) XOR sign(B); the most-negative operand magnitude (for example 128 for 8 bits) SHALL be represented exactly.
REQ-016 Each CALC cycle SHALL add the shifted multiplicand to the accumulator when the multiplier LSB is 1, then shift the multiplier right, shift the multiplicand left and decrement the counter.
REQ-017 CALC SHALL go to FINISH after the counter reaches zero, that is, after MULTIPLIER_WIDTH iterations, at edge k+MULTIPLIER_WIDTH.
REQ-018 FINISH SHALL load Y_REG with the accumulator, two's-complement negated when the negate flag is set, assert DONE, and return to IDLE.
REQ-019 Fixed latency: edge k to Y_REG and DONE valid SHALL be MULTIPLIER_WIDTH+1 cycles.
REQ-020 READY SHALL drop at edge k and rise again at edge k+MULTIPLIER_WIDTH+1.
REQ-021 GO, A, B and SIGNED_MODE SHALL be ignored outside IDLE; operand changes mid-operation SHALL NOT affect the result.
REQ-022 GO held high continuously SHALL start a new operation on every IDLE cycle, giving back-to-back operations one IDLE cycle apart.
REQ-023 Arithmetic SHALL be exact for all operand pairs with no overflow: the unsigned maximum fits PRODUCT_WIDTH, and the signed result is sign-correct across the full PRODUCT_WIDTH.
REQ-024 A zero operand SHALL produce Y_REG=0 with no negative zero, regardless of the negate flag.

Reset
REQ-025 FSM_ARESET low SHALL immediately force IDLE, Y_REG=0, DONE=0 and READY=1, and clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no DONE pulse.
REQ-027 After deassertion, the first GO SHALL be accepted on the first rising edge with FSM_ARESET high.

Configuration
REQ-028 Macro MULT_EARLY_TERM_EN, when defined, SHALL end CALC after any iteration that leaves the shifted multiplier at zero, so latency becomes (index of highest set bit of |B|)+2 cycles.
REQ-029 With MULT_EARLY_TERM_EN defined and |B|=0, CALC SHALL still execute exactly one iteration, giving latency 2.
REQ-030 Without MULT_EARLY_TERM_EN, latency SHALL be fixed per REQ-019 and no early-exit logic SHALL be present.

Verification
REQ-031 Defaults, unsigned, A=13, B=11, GO one cycle -> Y_REG=143 (0x008F), DONE pulse 9 cycles after the GO edge, READY low for exactly 9 cycles.
REQ-032 Unsigned A=255, B=255 -> 0xFE01; signed A=-128, B=-128 -> 0x4000; signed A=-3, B=5 -> 0xFFF1.
REQ-033 Signed A=0, B=-7 -> Y_REG=0x0000; A and B toggled randomly while busy -> result unchanged.
REQ-034 FSM_ARESET pulsed low at CALC iteration 4 -> no DONE, Y_REG=0, READY=1 at once; next GO with 6x7 -> 42.
REQ-035 GO held high for 3 operations -> three DONE pulses spaced 10 cycles apart, each with the correct product.
REQ-036 MULT_EARLY_TERM_EN defined, unsigned B=1 -> DONE 2 cycles after GO; B=0x80 -> 9 cycles; B=0 -> 2 cycles with Y_REG=0.
